// File: rtl/page_nway_subdivide_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : page_nway_subdivide_if                                          |
// | Brief    : Leaf-side and sub-page-side bus of page_nway_subdivide.         |
// |            Stats ports exist only when SUBDIV_STATS_EN is defined.         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface page_nway_subdivide_if #(
  parameter int NUM_SUB = 4,
  parameter int DATA_W  = 49
);
  logic                      ap_start;
  logic [DATA_W-1:0]         din_leaf_bft2interface;
  logic [DATA_W-1:0]         dout_leaf_interface2bft;
  logic                      resend;
  logic [NUM_SUB*DATA_W-1:0] sub_din;
  logic [NUM_SUB-1:0]        sub_din_rdy;
  logic [NUM_SUB*DATA_W-1:0] sub_dout;
  logic [NUM_SUB-1:0]        sub_dout_rdy;
  logic [NUM_SUB-1:0]        sub_ap_start;
  logic                      overflow;
`ifdef SUBDIV_STATS_EN
  logic [15:0]               drop_cnt;
  logic [NUM_SUB*16-1:0]     egress_cnt;
`endif

  modport slave (
    input  ap_start, din_leaf_bft2interface, resend, sub_din_rdy, sub_dout,
    output dout_leaf_interface2bft, sub_din, sub_dout_rdy, sub_ap_start, overflow
`ifdef SUBDIV_STATS_EN
    , output drop_cnt, egress_cnt
`endif
  );

  modport master (
    output ap_start, din_leaf_bft2interface, resend, sub_din_rdy, sub_dout,
    input  dout_leaf_interface2bft, sub_din, sub_dout_rdy, sub_ap_start, overflow
`ifdef SUBDIV_STATS_EN
    , input drop_cnt, egress_cnt
`endif
  );
endinterface
`default_nettype wire

// File: rtl/page_nway_subdivide.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : page_nway_subdivide                                             |
// | Brief    : Splits one BFT leaf into NUM_SUB buffered sub-page channels     |
// |            with round-robin egress and resend replay.                      |
// |            Optional counters: define SUBDIV_STATS_EN.                      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module page_nway_subdivide #(
  parameter int NUM_SUB    = 4,
  parameter int DATA_W     = 49,
  parameter int SEL_LSB    = 43,
  parameter int FIFO_DEPTH = 8
) (
  input  wire logic            clk_400,
  input  wire logic            reset_400,
  page_nway_subdivide_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_SUB);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [SEL_W-1:0] c_ptr_rst = SEL_W'(NUM_SUB - 1);
  localparam logic [AW:0]      c_one     = (AW+1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  logic                w_din_vld;
  logic [SEL_W-1:0]    w_sel;
  logic                w_drop;
  logic [NUM_SUB-1:0]  w_in_push, w_in_pop, w_in_empty, w_in_full;
  logic [NUM_SUB-1:0]  w_eg_push, w_eg_pop, w_eg_empty, w_eg_full;
  logic [DATA_W-1:0]   w_eg_head [NUM_SUB];
  logic                w_advance;
  logic                w_gnt_vld;
  logic [SEL_W-1:0]    w_gnt_idx;

  state_t              r_state;
  logic [DATA_W-1:0]   r_dout;
  logic [SEL_W-1:0]    r_ptr;
  logic [NUM_SUB-1:0]  r_ap;
  logic                r_overflow;

  assign w_din_vld = bus.din_leaf_bft2interface[DATA_W-1];
  assign w_sel     = bus.din_leaf_bft2interface[SEL_LSB +: SEL_W];
  // A valid word that no channel accepted was either mis-addressed or hit a full FIFO.
  assign w_drop    = w_din_vld && (w_in_push == '0);

  assign w_advance = (r_state == ST_IDLE) || !bus.resend;

  for (genvar k = 0; k < NUM_SUB; k++) begin : g_ch
    logic [DATA_W-1:0] r_in_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] r_eg_mem [FIFO_DEPTH];
    logic [AW:0]       r_in_wp, r_in_rp, r_eg_wp, r_eg_rp;
    logic [DATA_W-1:0] w_sub_word;

    assign w_sub_word    = bus.sub_dout[k*DATA_W +: DATA_W];

    assign w_in_empty[k] = (r_in_wp == r_in_rp);
    assign w_in_full[k]  = (r_in_wp == {~r_in_rp[AW], r_in_rp[AW-1:0]});
    assign w_in_push[k]  = w_din_vld && (w_sel == SEL_W'(k)) && !w_in_full[k];
    assign w_in_pop[k]   = !w_in_empty[k] && bus.sub_din_rdy[k];

    assign w_eg_empty[k] = (r_eg_wp == r_eg_rp);
    assign w_eg_full[k]  = (r_eg_wp == {~r_eg_rp[AW], r_eg_rp[AW-1:0]});
    assign w_eg_push[k]  = w_sub_word[DATA_W-1] && !w_eg_full[k];
    assign w_eg_pop[k]   = w_advance && w_gnt_vld && (w_gnt_idx == SEL_W'(k));
    assign w_eg_head[k]  = r_eg_mem[r_eg_rp[AW-1:0]];

    // Stale storage is masked so an empty channel presents an all-zero word.
    assign bus.sub_din[k*DATA_W +: DATA_W] =
      w_in_empty[k] ? '0 : r_in_mem[r_in_rp[AW-1:0]];

    always_ff @(posedge clk_400) begin
      if (w_in_push[k]) r_in_mem[r_in_wp[AW-1:0]] <= bus.din_leaf_bft2interface;
      if (w_eg_push[k]) r_eg_mem[r_eg_wp[AW-1:0]] <= w_sub_word;
    end

    always_ff @(posedge clk_400) begin
      if (!reset_400) begin
        r_in_wp <= '0;
        r_in_rp <= '0;
        r_eg_wp <= '0;
        r_eg_rp <= '0;
      end else begin
        if (w_in_push[k]) r_in_wp <= r_in_wp + c_one;
        if (w_in_pop[k])  r_in_rp <= r_in_rp + c_one;
        if (w_eg_push[k]) r_eg_wp <= r_eg_wp + c_one;
        if (w_eg_pop[k])  r_eg_rp <= r_eg_rp + c_one;
      end
    end

`ifdef SUBDIV_STATS_EN
    logic [15:0] r_eg_cnt;

    always_ff @(posedge clk_400) begin
      if (!reset_400) begin
        r_eg_cnt <= '0;
      end else if (w_eg_pop[k]) begin
        r_eg_cnt <= r_eg_cnt + 16'd1;
      end
    end

    assign bus.egress_cnt[k*16 +: 16] = r_eg_cnt;
`endif
  end

  // Descending scan so the channel closest after r_ptr is written last and wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int i = NUM_SUB; i >= 1; i--) begin
      if (!w_eg_empty[(int'(r_ptr) + i) % NUM_SUB]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = SEL_W'((int'(r_ptr) + i) % NUM_SUB);
      end
    end
  end

  always_ff @(posedge clk_400) begin
    if (!reset_400) begin
      r_state <= ST_IDLE;
      r_dout  <= '0;
      r_ptr   <= c_ptr_rst;
    end else if (w_advance) begin
      if (w_gnt_vld) begin
        r_state <= ST_SEND;
        r_dout  <= w_eg_head[w_gnt_idx];
        r_ptr   <= w_gnt_idx;
      end else begin
        r_state <= ST_IDLE;
        r_dout  <= '0;
      end
    end else begin
      r_state <= ST_HOLD;
    end
  end

  always_ff @(posedge clk_400) begin
    if (!reset_400) begin
      r_ap       <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_ap <= {NUM_SUB{bus.ap_start}};
      if (w_drop) r_overflow <= 1'b1;
    end
  end

`ifdef SUBDIV_STATS_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk_400) begin
    if (!reset_400) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign bus.drop_cnt = r_drop_cnt;
`endif

  assign bus.dout_leaf_interface2bft = r_dout;
  assign bus.sub_dout_rdy            = ~w_eg_full;
  assign bus.sub_ap_start            = r_ap;
  assign bus.overflow                = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_page_nway_subdivide.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_page_nway_subdivide                                          |
// | Brief    : Directed vector bench for page_nway_subdivide (4 ch, depth 8).  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_page_nway_subdivide;
  localparam int NS = 4;
  localparam int DW = 49;
  localparam int BW = NS * DW;

  logic clk = 1'b0;
  logic reset_400;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  page_nway_subdivide_if #(.NUM_SUB(NS), .DATA_W(DW)) bus ();

  page_nway_subdivide #(
    .NUM_SUB(NS), .DATA_W(DW), .SEL_LSB(43), .FIFO_DEPTH(8)
  ) dut (
    .clk_400  (clk),
    .reset_400(reset_400),
    .bus      (bus)
  );

  typedef struct {
    logic [DW-1:0] din;
    logic          ap;
    logic [BW-1:0] exp_sub_din;
    logic [NS-1:0] exp_ap;
  } vec_t;

  vec_t vecs [6];

  // Packet: valid at bit 48, select at [44:43], payload at [31:0].
  function automatic logic [DW-1:0] pk(input int s, input logic [31:0] p);
    logic [DW-1:0] w;
    w = '0;
    w[DW-1]  = 1'b1;
    w[44:43] = s[1:0];
    w[31:0]  = p;
    return w;
  endfunction

  function automatic logic [BW-1:0] at(input int k, input logic [DW-1:0] p);
    logic [BW-1:0] v;
    v = '0;
    v[k*DW +: DW] = p;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0] = '{pk(2, 32'hCAFE0002), 1'b0, at(2, pk(2, 32'hCAFE0002)), 4'h0};
    vecs[1] = '{pk(0, 32'h11110000), 1'b1, at(0, pk(0, 32'h11110000)), 4'hF};
    vecs[2] = '{pk(3, 32'h33330003), 1'b1, at(3, pk(3, 32'h33330003)), 4'hF};
    vecs[3] = '{'0,                  1'b0, '0,                          4'h0};
    vecs[4] = '{pk(1, 32'h0BAD0001), 1'b0, at(1, pk(1, 32'h0BAD0001)), 4'h0};
    vecs[5] = '{'0,                  1'b1, '0,                          4'hF};

    bus.ap_start               = 1'b0;
    bus.din_leaf_bft2interface = '0;
    bus.resend                 = 1'b0;
    bus.sub_din_rdy            = '1;
    bus.sub_dout               = '0;
    reset_400                  = 1'b0;
    step();
    step();
    chk("rst_dout", bus.dout_leaf_interface2bft, '0);
    chk("rst_sub_din", bus.sub_din, '0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_ap_start", bus.sub_ap_start, 0);
    chk("rst_dout_rdy", bus.sub_dout_rdy, 4'hF);
    reset_400 = 1'b1;
    step();
    chk("idle_dout", bus.dout_leaf_interface2bft, '0);

    // Ingress routing and ap_start distribution, one word per cycle.
    for (int i = 0; i < 6; i++) begin
      bus.din_leaf_bft2interface = vecs[i].din;
      bus.ap_start               = vecs[i].ap;
      step();
      chk($sformatf("vec%0d_sub_din", i), bus.sub_din, vecs[i].exp_sub_din);
      chk($sformatf("vec%0d_ap_start", i), bus.sub_ap_start, vecs[i].exp_ap);
      chk($sformatf("vec%0d_overflow", i), bus.overflow, 0);
    end
    bus.din_leaf_bft2interface = '0;
    bus.ap_start               = 1'b0;

    // Fill channel 1 past its depth while blocked.
    bus.sub_din_rdy = 4'b1101;
    for (int i = 0; i < 9; i++) begin
      bus.din_leaf_bft2interface = pk(1, 32'h100 + i);
      step();
      if (i == 7) chk("ovf_before_drop", bus.overflow, 0);
    end
    bus.din_leaf_bft2interface = '0;
    chk("ovf_after_drop", bus.overflow, 1);
`ifdef SUBDIV_STATS_EN
    chk("drop_cnt_1", bus.drop_cnt, 16'd1);
`endif
    bus.sub_din_rdy = '1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain1_%0d", i), bus.sub_din, at(1, pk(1, 32'h100 + i)));
      step();
    end
    chk("drain1_empty", bus.sub_din, '0);

    // Push into a full FIFO on the same edge it pops: still dropped.
    bus.sub_din_rdy = 4'b1011;
    for (int i = 0; i < 8; i++) begin
      bus.din_leaf_bft2interface = pk(2, 32'h200 + i);
      step();
    end
    bus.sub_din_rdy            = '1;
    bus.din_leaf_bft2interface = pk(2, 32'h2FF);
    step();
    bus.din_leaf_bft2interface = '0;
`ifdef SUBDIV_STATS_EN
    chk("drop_cnt_2", bus.drop_cnt, 16'd2);
`endif
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("drain2_%0d", i), bus.sub_din, at(2, pk(2, 32'h200 + i)));
      step();
    end
    chk("drain2_empty", bus.sub_din, '0);

    // All four egress channels at once.
    for (int k = 0; k < NS; k++) bus.sub_dout[k*DW +: DW] = pk(k, 32'hE000 + k);
    step();
    bus.sub_dout = '0;
    chk("eg_latency", bus.dout_leaf_interface2bft, '0);
    for (int k = 0; k < NS; k++) begin
      step();
      chk($sformatf("eg_ch%0d", k), bus.dout_leaf_interface2bft, pk(k, 32'hE000 + k));
    end
    step();
    chk("eg_idle", bus.dout_leaf_interface2bft, '0);

    // Grant channel 3, replay for two cycles, then wrap to channel 0.
    bus.sub_dout[3*DW +: DW] = pk(3, 32'hD003);
    step();
    chk("rs_latency", bus.dout_leaf_interface2bft, '0);
    bus.sub_dout = '0;
    bus.sub_dout[0 +: DW]    = pk(0, 32'hD000);
    bus.sub_dout[2*DW +: DW] = pk(2, 32'hD002);
    step();
    chk("rs_grant3", bus.dout_leaf_interface2bft, pk(3, 32'hD003));
    bus.sub_dout = '0;
    bus.resend   = 1'b1;
    step();
    chk("rs_hold1", bus.dout_leaf_interface2bft, pk(3, 32'hD003));
    step();
    chk("rs_hold2", bus.dout_leaf_interface2bft, pk(3, 32'hD003));
    bus.resend = 1'b0;
    step();
    chk("rs_wrap0", bus.dout_leaf_interface2bft, pk(0, 32'hD000));
    step();
    chk("rs_next2", bus.dout_leaf_interface2bft, pk(2, 32'hD002));
    step();
    chk("rs_idle", bus.dout_leaf_interface2bft, '0);

    // resend has no effect while idle.
    bus.resend = 1'b1;
    bus.sub_dout[DW +: DW] = pk(1, 32'hC001);
    step();
    bus.sub_dout = '0;
    chk("ir_latency", bus.dout_leaf_interface2bft, '0);
    step();
    chk("ir_grant1", bus.dout_leaf_interface2bft, pk(1, 32'hC001));
    bus.resend = 1'b0;
    step();
    chk("ir_idle", bus.dout_leaf_interface2bft, '0);
`ifdef SUBDIV_STATS_EN
    chk("egress_cnt", bus.egress_cnt, {16'd2, 16'd2, 16'd2, 16'd2});
`endif

    // Reset while in HOLD with partly filled FIFOs.
    bus.sub_din_rdy = '0;
    for (int i = 0; i < 4; i++) begin
      bus.din_leaf_bft2interface = pk(0, 32'h500 + i);
      bus.sub_dout[0 +: DW]      = pk(0, 32'h600 + i);
      step();
      if (i == 1) begin
        chk("hr_grant", bus.dout_leaf_interface2bft, pk(0, 32'h600));
        bus.resend = 1'b1;
      end
    end
    bus.din_leaf_bft2interface = '0;
    bus.sub_dout               = '0;
    chk("hr_hold", bus.dout_leaf_interface2bft, pk(0, 32'h600));
    chk("hr_ingress", bus.sub_din, at(0, pk(0, 32'h500)));
    bus.ap_start = 1'b1;
    reset_400    = 1'b0;
    step();
    chk("rst2_dout", bus.dout_leaf_interface2bft, '0);
    chk("rst2_sub_din", bus.sub_din, '0);
    chk("rst2_overflow", bus.overflow, 0);
    chk("rst2_ap_start", bus.sub_ap_start, 0);
    chk("rst2_dout_rdy", bus.sub_dout_rdy, 4'hF);
`ifdef SUBDIV_STATS_EN
    chk("rst2_drop_cnt", bus.drop_cnt, 0);
    chk("rst2_egress_cnt", bus.egress_cnt, 0);
`endif
    reset_400    = 1'b1;
    bus.resend   = 1'b0;
    bus.ap_start = 1'b0;
    step();
    step();
    chk("post_dout", bus.dout_leaf_interface2bft, '0);
    chk("post_sub_din", bus.sub_din, '0);
    bus.sub_dout[0 +: DW]  = pk(0, 32'h700);
    bus.sub_dout[DW +: DW] = pk(1, 32'h701);
    step();
    bus.sub_dout = '0;
    chk("post_latency", bus.dout_leaf_interface2bft, '0);
    step();
    chk("post_first0", bus.dout_leaf_interface2bft, pk(0, 32'h700));
    step();
    chk("post_next1", bus.dout_leaf_interface2bft, pk(1, 32'h701));
    step();
    chk("post_idle", bus.dout_leaf_interface2bft, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/page_nway_subdivide.md
Name: page_nway_subdivide

Overview:
- Parametrised successor to the fixed quad/double page-subdivide wrappers.
- Splits one BFT leaf interface into NUM_SUB sub-page channels inside a parent DFX pblock.
- Adds per-channel ingress/egress FIFO buffering, round-robin egress arbitration, resend replay, and registered per-channel ap_start distribution.
- Sits between a BFT leaf and NUM_SUB child page pblocks.

Parameters:
NUM_SUB, 4, number of sub-page channels (2..16)
DATA_W, 49, leaf packet width; bit DATA_W-1 is the valid flag
SEL_LSB, 43, LSB of the sub-page select field in the packet
FIFO_DEPTH, 8, entries per ingress and per egress FIFO; power of 2, at least 2
SEL_W, clog2(NUM_SUB), derived width of the select field; not to be overridden

Ports:
clk_400  in  1  single clock for all logic
reset_400  in  1  synchronous, active-low reset
ap_start  in  1  page start from the static region
din_leaf_bft2interface  in  DATA_W  packet from the BFT leaf
dout_leaf_interface2bft  out  DATA_W  packet to the BFT leaf
resend  in  1  BFT rejected the word driven in the previous cycle
sub_din  out  NUM_SUB*DATA_W  per-channel packet to the sub-page; channel k occupies slice [k*DATA_W +: DATA_W]
sub_din_rdy  in  NUM_SUB  sub-page k accepts sub_din slice k
sub_dout  in  NUM_SUB*DATA_W  per-channel packet from the sub-page
sub_dout_rdy  out  NUM_SUB  egress FIFO k not full
sub_ap_start  out  NUM_SUB  registered copy of ap_start, one bit per channel
overflow  out  1  sticky ingress drop flag

Behaviour:
- Reset (reset_400=0 at a clk_400 edge) takes effect at that edge and produces:
  - all FIFOs empty; dout_leaf_interface2bft=0; every sub_din valid bit=0;
  - sub_ap_start=0; overflow=0; round-robin pointer=NUM_SUB-1, so the first grant goes to channel 0.
- Reset mid-operation discards all buffered packets, including any word under resend.
- Ingress:
  - Packet with din[DATA_W-1]=1 at edge t: sel=din[SEL_LSB +: SEL_W].
  - If sel<NUM_SUB and ingress FIFO[sel] is not full (evaluated before any same-cycle pop): push.
  - Otherwise: drop and set overflow.
  - The full check never uses bypass: a push into a full FIFO drops even if the same edge pops it.
- Sub-side output:
  - sub_din slice k = head of ingress FIFO k, with valid bit = !empty_k.
  - Pop when valid and sub_din_rdy[k]=1.
  - Latency: packet at edge t appears on the sub port in cycle t+1 when the FIFO was empty.
- Egress capture: sub_dout slice k valid and sub_dout_rdy[k]=1 at an edge -> push into egress FIFO k. sub_dout_rdy[k]=!full_k.
- Egress arbiter (registered output), states IDLE / SEND / HOLD:
  - IDLE: no egress FIFO non-empty; dout=0.
  - Grant: the first non-empty FIFO searching from pointer+1 modulo NUM_SUB. Register its head onto dout, pop it, update the pointer to the grant, go to SEND.
  - SEND: if resend=1, dout is unchanged and the state goes to HOLD. Otherwise grant the next packet the same cycle (1 packet/cycle sustained), or go to IDLE with dout=0.
  - HOLD: dout is held while resend=1; resend=0 behaves as SEND with resend=0.
  - resend is ignored in IDLE.
- Pointer wraps from NUM_SUB-1 to 0.
- sub_ap_start[k] <= ap_start every cycle; 1-cycle latency, all channels identical.
- Simultaneous push and pop on a non-full, non-empty FIFO: occupancy unchanged, order preserved.

Optional Feature:
- Macro: SUBDIV_STATS_EN.
- Defined:
  - Adds output drop_cnt [15:0], incremented per dropped ingress packet; saturates at 16'hFFFF; reset to 0.
  - Adds output egress_cnt [NUM_SUB*16-1:0], a per-channel count of packets granted onto dout. Replays under HOLD are not counted. Wraps modulo 2^16.
- Undefined: neither port nor its counters exist; overflow is the only error indication.

Test Plan:
- Reset then idle -> dout=0, sub_din valids 0, overflow=0, sub_ap_start=0.
- Inject din with sel=2, payload 32'hCAFE0002 at edge t, with sub_din_rdy=all 1 -> sub_din slice 2 carries it in cycle t+1; the other slices stay invalid.
- Hold sub_din_rdy[1]=0 and inject 9 packets with sel=1 (FIFO_DEPTH=8):
  - first 8 are buffered, the 9th is dropped and overflow=1;
  - with SUBDIV_STATS_EN, drop_cnt=1;
  - releasing rdy delivers 8 packets in order.
- All four sub_dout channels send one packet in the same cycle -> dout shows channels 0,1,2,3 on consecutive cycles, then IDLE.
- Grant channel 3, then assert resend for 2 cycles -> the same word is held on dout for 3 cycles total. The next grant is channel 0 (pointer wrap). With SUBDIV_STATS_EN, egress_cnt[3] increments by 1 only.
- Assert reset_400=0 while HOLD is active and FIFOs are half full -> on the next edge all outputs are 0 and FIFOs are empty. After release, the first grant goes to channel 0.
